// File: rtl/swap_pkg.sv
// swap_pkg: types and constants shared by the swap scheduler slice.
//   state_t          - scheduler FSM states
//   LAST_SERVED_RST  - last-served value after reset, so requester 0
//                      wins the first tie
package swap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic LAST_SERVED_RST = 1'b1;

endpackage

// File: rtl/swap_stage.sv
// swap_stage: two WIDTH-bit registers that can be loaded with a new pair
// or exchanged with each other in a single cycle.
//   clk, rst_n  - clock, asynchronous active-low reset (clears both regs)
//   load        - capture a_in/b_in (has priority over en)
//   en          - simultaneous exchange a<-b, b<-a
//   a_in, b_in  - pair to load
//   a_o, b_o    - current register contents
module swap_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (load) begin
            a_reg <= a_in;
            b_reg <= b_in;
        end else if (en) begin
            a_reg <= b_reg;
            b_reg <= a_reg;
        end
    end

    assign a_o = a_reg;
    assign b_o = b_reg;

endmodule

// File: rtl/swap_sched.sv
// swap_sched: round-robin scheduler sharing one swap_stage between two
// requesters. A granted pair is loaded into the stage, exchanged n times,
// then presented on a valid/ready response port.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   reqX_valid/ready           - request handshake (ready is combinational)
//   reqX_a, reqX_b, reqX_n     - operand pair and swap count
//   resp_valid/ready           - response handshake
//   resp_id, resp_a, resp_b    - owner and final pair (registered)
//   busy                       - high whenever the FSM is not IDLE
module swap_sched
    import swap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CNT_W-1:0] req0_n,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CNT_W-1:0] req1_n,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_a,
    output logic [WIDTH-1:0] resp_b,
    output logic             busy
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_served_reg;
    logic             resp_id_reg;
    logic             resp_valid_reg;
    logic             busy_reg;

    logic             grant_id;
    logic             load;
    logic             en;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [CNT_W-1:0] sel_n;

    // Operand mux driven by the arbiter's choice.
    assign sel_a = grant_id ? req1_a : req0_a;
    assign sel_b = grant_id ? req1_b : req0_b;
    assign sel_n = grant_id ? req1_n : req0_n;

    always_comb begin
        state_next = state_reg;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant_id   = 1'b0;
        load       = 1'b0;
        en         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie, serve whoever did not go last.
                    grant_id   = (req0_valid && req1_valid) ? ~last_served_reg : req1_valid;
                    load       = 1'b1;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = (sel_n != '0) ? SWAP : RESP;
                end
            end
            SWAP: begin
                en = 1'b1;
                if (cnt_reg == CNT_W'(1)) state_next = RESP;
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            last_served_reg <= LAST_SERVED_RST;
            resp_id_reg     <= 1'b0;
            resp_valid_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Flags follow the next state so they line up with the stage
            // contents captured on the same edge.
            resp_valid_reg <= (state_next == RESP);
            busy_reg       <= (state_next != IDLE);
            if (load) begin
                cnt_reg         <= sel_n;
                resp_id_reg     <= grant_id;
                last_served_reg <= grant_id;
            end else if (en) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
        end
    end

    // The stage registers double as the response data registers: they stop
    // changing once the FSM reaches RESP, so the pair is held until taken.
    swap_stage #(
        .WIDTH(WIDTH)
    ) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .en   (en),
        .a_in (sel_a),
        .b_in (sel_b),
        .a_o  (resp_a),
        .b_o  (resp_b)
    );

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign busy       = busy_reg;

endmodule
